vga_timing_detect: RTL and testbench
====================================

VGA_TIMING_DETECT -- requirements
Module: vga_timing_detect

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive matching frames required to assert locked.
REQ-002 SHALL have parameter CNT_W, default 13, meaning width of all timing counters.
REQ-003 SHALL have port sys_clk  input  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vid_de  input  1  active-video enable, active-high.
REQ-006 SHALL have port vid_hs  input  1  line sync, active-high.
REQ-007 SHALL have port vid_vs  input  1  frame sync, active-high.
REQ-008 SHALL have port vid_rgb  input  24  pixel data {R,G,B}.
REQ-009 SHALL have port pix_rgb  output  24  registered copy of vid_rgb.
REQ-010 SHALL have port pix_vld  output  1  registered copy of vid_de.
REQ-011 SHALL have port pix_x  output  CNT_W  column index of current pix_rgb.
REQ-012 SHALL have port pix_y  output  CNT_W  row index of current pix_rgb.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse on vid_vs rising edge.
REQ-014 SHALL have ports h_total, h_active, v_total, v_active  output  CNT_W each  measured timing of last complete frame.
REQ-015 SHALL have port locked  output  1  timing stable for LOCK_FRAMES frames.
REQ-016 SHALL have port err  output  1  sticky: counter saturation or lock loss seen; cleared only by reset.

Function
REQ-017 Edge detection SHALL use one registered copy of each sync input; rise = current high and previous low.
REQ-018 pix_rgb, pix_vld, pix_x, pix_y SHALL have exactly 1 cycle latency from vid_rgb/vid_de.
REQ-019 pix_x SHALL be 0 for the first vid_de-high cycle of a line, increment per vid_de-high cycle, return to 0 after vid_de falls.
REQ-020 pix_y SHALL increment on each vid_de falling edge and clear to 0 on vid_vs rise; first active line has pix_y 0.
REQ-021 Line counter SHALL count cycles between vid_hs rises; at each vid_hs rise latch count into line-length register, restart at 1.
REQ-022 DE counter SHALL count vid_de-high cycles per line; at vid_de fall latch into line-active register.
REQ-023 Frame counters SHALL count vid_hs rises (lines) and vid_de falls (active lines) between vid_vs rises.
REQ-024 At each vid_vs rise, h_total/h_active/v_total/v_active SHALL update simultaneously from the latched line-length, line-active, line count, active-line count.
REQ-025 Any counter reaching 2^CNT_W-1 SHALL hold (saturate) and set err; a saturated frame SHALL count as mismatching.
REQ-026 FSM states: SEARCH, MEASURE, LOCKED.
REQ-027 SEARCH -> MEASURE on first vid_vs rise (counters cleared; no outputs updated from partial frame).
REQ-028 MEASURE: on each vid_vs rise compare new 4-tuple to previous; match increments match count, mismatch clears it; match count = LOCK_FRAMES-1 -> LOCKED.
REQ-029 LOCKED: locked=1; vid_vs rise with mismatch -> SEARCH-equivalent restart into MEASURE, locked=0 next cycle, err set.
REQ-030 LOCK_FRAMES=1 SHALL lock on the second vid_vs rise (first complete frame).
REQ-031 vid_hs rise and vid_vs rise in same cycle SHALL be processed together: line count includes that line, then frame counters restart.
REQ-032 vid_de high while vid_vs high SHALL be counted normally; no error.

Reset
REQ-033 On sys_rst_n low, all outputs SHALL be 0 asynchronously, FSM=SEARCH, all counters and match count 0.
REQ-034 Reset release mid-frame SHALL ignore the partial frame; first measurement window starts at next vid_vs rise.

Verification
REQ-035 1080p60 source (2200x1125, sync 44/5, active 1920x1080), LOCK_FRAMES=2 -> after 3rd vid_vs rise locked=1, h_total=2200, h_active=1920, v_total=1125, v_active=1080, err=0.
REQ-036 Same source -> first active pixel pix_x=0,pix_y=0; last active pixel pix_x=1919,pix_y=1079; pix_rgb equals vid_rgb delayed 1 cycle.
REQ-037 Locked 1080p, switch to 640x480 (800x525) -> locked=0 one cycle after first mismatching vid_vs rise, err=1, relock with h_total=800, v_total=525 after 2 more frames.
REQ-038 Hold vid_vs low for 8200 lines -> line counter saturates at 8191, err=1, locked stays 0.
REQ-039 Assert sys_rst_n low mid-line while locked -> all outputs 0 immediately; after release, locked=0 until 3rd subsequent vid_vs rise.
REQ-040 Stimulus with vid_hs and vid_vs rising same cycle -> v_total counts that line; frame_start pulses exactly 1 cycle.

Source files
------------

// File: rtl/vga_timing_detect.sv
// Video timing detector: measures line/frame geometry from DE/HS/VS and
// declares lock once the measured timing repeats for LOCK_FRAMES frames.
// It also forwards the pixel stream with column/row coordinates attached.
module vga_timing_detect #(
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 13
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             vid_de,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic [23:0]      vid_rgb,
    output logic [23:0]      pix_rgb,
    output logic             pix_vld,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_hs_d;
    logic             r_vs_d;
    logic             r_de_d;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_line_len;
    logic [CNT_W-1:0] r_de_cnt;
    logic [CNT_W-1:0] r_line_act;
    logic [CNT_W-1:0] r_fr_lines;
    logic [CNT_W-1:0] r_fr_act;
    logic             r_sat_fr;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_have_prev;

    logic             w_hs_rise;
    logic             w_vs_rise;
    logic             w_de_fall;
    logic [CNT_W-1:0] w_ht_new;
    logic [CNT_W-1:0] w_ha_new;
    logic [CNT_W-1:0] w_vt_new;
    logic [CNT_W-1:0] w_va_new;
    logic             w_sat_cnt;
    logic             w_sat_pix;
    logic             w_frame_sat;
    logic             w_match;
    logic [CNT_W-1:0] w_match_nxt;
    logic             w_prev_nxt;
    logic             w_upd;
    logic             w_lock_loss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    assign w_hs_rise = vid_hs & ~r_hs_d;
    assign w_vs_rise = vid_vs & ~r_vs_d;
    assign w_de_fall = ~vid_de & r_de_d;

    // A line or frame boundary landing on the VS rise cycle belongs to the
    // frame that is ending, so the closing values are taken pre-latch.
    assign w_ht_new = w_hs_rise ? r_line_cnt : r_line_len;
    assign w_ha_new = w_de_fall ? r_de_cnt : r_line_act;
    assign w_vt_new = sat_inc(r_fr_lines, w_hs_rise);
    assign w_va_new = sat_inc(r_fr_act, w_de_fall);

    assign w_sat_cnt = (r_line_cnt == CNT_MAX) | (r_de_cnt == CNT_MAX) |
                       (r_fr_lines == CNT_MAX) | (r_fr_act == CNT_MAX);
    assign w_sat_pix = (r_col == CNT_MAX) | (r_row == CNT_MAX);
    assign w_frame_sat = r_sat_fr | w_sat_cnt | (w_vt_new == CNT_MAX) | (w_va_new == CNT_MAX);

    assign w_match = r_have_prev & ~w_frame_sat &
                     (w_ht_new == h_total) & (w_ha_new == h_active) &
                     (w_vt_new == v_total) & (w_va_new == v_active);

    // Sync edge history and one-cycle pixel pipeline with coordinates
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hs_d      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_de_d      <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            pix_rgb     <= '0;
            pix_vld     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            r_hs_d      <= vid_hs;
            r_vs_d      <= vid_vs;
            r_de_d      <= vid_de;
            pix_rgb     <= vid_rgb;
            pix_vld     <= vid_de;
            pix_x       <= vid_de ? r_col : '0;
            pix_y       <= vid_de ? r_row : '0;
            frame_start <= w_vs_rise;
            r_col       <= vid_de ? sat_inc(r_col, 1'b1) : '0;
            if (w_vs_rise) begin
                r_row <= '0;
            end else if (w_de_fall) begin
                r_row <= sat_inc(r_row, 1'b1);
            end
        end
    end

    // Line length, line active width and per-frame line counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_line_cnt <= '0;
            r_line_len <= '0;
            r_de_cnt   <= '0;
            r_line_act <= '0;
            r_fr_lines <= '0;
            r_fr_act   <= '0;
            r_sat_fr   <= 1'b0;
        end else begin
            if (w_hs_rise) begin
                r_line_len <= r_line_cnt;
                r_line_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_line_cnt <= sat_inc(r_line_cnt, 1'b1);
            end
            if (w_de_fall) begin
                r_line_act <= r_de_cnt;
            end
            r_de_cnt <= vid_de ? sat_inc(r_de_cnt, 1'b1) : '0;
            if (w_vs_rise) begin
                r_fr_lines <= '0;
                r_fr_act   <= '0;
                r_sat_fr   <= 1'b0;
            end else begin
                r_fr_lines <= sat_inc(r_fr_lines, w_hs_rise);
                r_fr_act   <= sat_inc(r_fr_act, w_de_fall);
                r_sat_fr   <= r_sat_fr | w_sat_cnt;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            r_have_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_have_prev <= w_prev_nxt;
        end
    end

    // Lock FSM next state: a lock loss restarts exactly like leaving SEARCH,
    // so the frame after the loss is compared against nothing
    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match_cnt;
        w_prev_nxt  = r_have_prev;
        w_upd       = 1'b0;
        w_lock_loss = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vs_rise) begin
                    w_state_nxt = MEASURE;
                    w_match_nxt = '0;
                    w_prev_nxt  = 1'b0;
                end
            end
            MEASURE: begin
                if (w_vs_rise) begin
                    w_upd       = 1'b1;
                    w_prev_nxt  = 1'b1;
                    w_match_nxt = w_match ? r_match_cnt + 1'b1 : '0;
                    if (!w_frame_sat && (w_match_nxt >= LOCK_TGT)) begin
                        w_state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_vs_rise) begin
                    w_upd = 1'b1;
                    if (!w_match) begin
                        w_state_nxt = MEASURE;
                        w_match_nxt = '0;
                        w_prev_nxt  = 1'b0;
                        w_lock_loss = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    // Published timing, lock flag and sticky error
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_total  <= '0;
            h_active <= '0;
            v_total  <= '0;
            v_active <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (w_upd) begin
                h_total  <= w_ht_new;
                h_active <= w_ha_new;
                v_total  <= w_vt_new;
                v_active <= w_va_new;
            end
            locked <= (w_state_nxt == LOCKED);
            err    <= err | w_sat_cnt | w_sat_pix | w_lock_loss | (w_vs_rise & w_frame_sat);
        end
    end

endmodule

// File: tb/tb_vga_timing_detect.sv
// Directed bench for vga_timing_detect using scaled-down video modes
// (20x10 with 12x6 active, and 16x8 with 10x5 active) and an 8-bit counter
// width so saturation is reachable in a short run.
module tb_vga_timing_detect;

    localparam int CW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          vid_de = 1'b0;
    logic          vid_hs = 1'b0;
    logic          vid_vs = 1'b0;
    logic [23:0]   vid_rgb = '0;

    logic [23:0]   pix_rgb;
    logic          pix_vld;
    logic [CW-1:0] pix_x, pix_y;
    logic          frame_start;
    logic [CW-1:0] h_total, h_active, v_total, v_active;
    logic          locked, err;

    logic [23:0]   d1_pix_rgb;
    logic          d1_pix_vld;
    logic [CW-1:0] d1_pix_x, d1_pix_y;
    logic          d1_frame_start;
    logic [CW-1:0] d1_h_total, d1_h_active, d1_v_total, d1_v_active;
    logic          d1_locked, d1_err;

    int total = 0;
    int bad   = 0;

    bit            chk_en = 1'b0;
    logic          p_de = 1'b0;
    logic [23:0]   p_rgb = '0;
    logic [CW-1:0] p_x = '0, p_y = '0;
    bit            p_first = 1'b0, p_last = 1'b0;
    int            stream_err = 0;
    int            fs_cnt = 0;
    logic [CW-1:0] first_x, first_y, last_x, last_y;

    vga_timing_detect #(.LOCK_FRAMES(2), .CNT_W(CW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
        .pix_rgb(pix_rgb), .pix_vld(pix_vld), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .locked(locked), .err(err)
    );

    vga_timing_detect #(.LOCK_FRAMES(1), .CNT_W(CW)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
        .pix_rgb(d1_pix_rgb), .pix_vld(d1_pix_vld), .pix_x(d1_pix_x), .pix_y(d1_pix_y),
        .frame_start(d1_frame_start),
        .h_total(d1_h_total), .h_active(d1_h_active), .v_total(d1_v_total), .v_active(d1_v_active),
        .locked(d1_locked), .err(d1_err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One pixel clock: check what the DUT made of the previous cycle, then drive the next.
    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic [CW-1:0] x, input logic [CW-1:0] y,
                        input bit is_first, input bit is_last);
        logic [23:0] rgb;
        @(negedge sys_clk);
        if (frame_start === 1'b1) fs_cnt++;
        if (chk_en) begin
            if (pix_vld !== p_de || pix_rgb !== p_rgb) stream_err++;
            else if (p_de && (pix_x !== p_x || pix_y !== p_y)) stream_err++;
            if (p_first) begin first_x = pix_x; first_y = pix_y; end
            if (p_last) begin last_x = pix_x; last_y = pix_y; end
        end
        rgb = 24'($urandom);
        vid_de = de; vid_hs = hs; vid_vs = vs; vid_rgb = rgb;
        p_de = de; p_rgb = rgb; p_x = x; p_y = y; p_first = is_first; p_last = is_last;
    endtask

    // Frame layout: active lines first, VS on the last line rising together with HS.
    task automatic gen_frame(input int ht, input int hsw, input int hst, input int ha,
                             input int vt, input int va, input bit vs_on);
        logic de, hs, vs;
        for (int l = 0; l < vt; l++) begin
            for (int p = 0; p < ht; p++) begin
                de = (l < va) && (p >= hst) && (p < hst + ha);
                hs = (p < hsw);
                vs = vs_on && (l == vt - 1);
                step(de, hs, vs, CW'(p - hst), CW'(l),
                     de && (l == 0) && (p == hst),
                     de && (l == va - 1) && (p == hst + ha - 1));
            end
        end
    endtask

    task automatic frame_a();
        gen_frame(20, 2, 4, 12, 10, 6, 1'b1);
    endtask

    task automatic frame_b();
        gen_frame(16, 2, 3, 10, 8, 5, 1'b1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0; vid_rgb = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        p_de = 1'b0; p_rgb = '0; p_first = 1'b0; p_last = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        vid_de = 1'b1; vid_hs = 1'b1; vid_vs = 1'b1; vid_rgb = 24'hABCDEF;
        repeat (3) @(negedge sys_clk);
        total++; if (pix_rgb !== 24'h0) begin bad++; $display("FAIL rst_rgb: got %h want 000000", pix_rgb); end
        total++; if ({pix_vld, frame_start, locked, err} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000", {pix_vld, frame_start, locked, err}); end
        total++; if ({pix_x, pix_y} !== '0) begin bad++; $display("FAIL rst_xy: got %0d,%0d want 0,0", pix_x, pix_y); end
        total++; if ({h_total, h_active, v_total, v_active} !== '0) begin bad++; $display("FAIL rst_timing: got %0d %0d %0d %0d want 0", h_total, h_active, v_total, v_active); end
    endtask

    task automatic test_lock();
        do_reset();
        chk_en = 1'b1; stream_err = 0;
        frame_a();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_f1: locked=%b want 0", locked); end
        total++; if (h_total !== 8'd0) begin bad++; $display("FAIL partial_frame: h_total=%0d want 0", h_total); end
        total++; if (d1_locked !== 1'b0) begin bad++; $display("FAIL lock1_f1: locked=%b want 0", d1_locked); end
        fs_cnt = 0;
        frame_a();
        total++; if (h_total !== 8'd20) begin bad++; $display("FAIL h_total: got %0d want 20", h_total); end
        total++; if (h_active !== 8'd12) begin bad++; $display("FAIL h_active: got %0d want 12", h_active); end
        total++; if (v_total !== 8'd10) begin bad++; $display("FAIL v_total_same_cycle: got %0d want 10", v_total); end
        total++; if (v_active !== 8'd6) begin bad++; $display("FAIL v_active: got %0d want 6", v_active); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_f2: locked=%b want 0", locked); end
        total++; if (d1_locked !== 1'b1) begin bad++; $display("FAIL lock1_f2: locked=%b want 1", d1_locked); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL frame_start_width: %0d cycles want 1", fs_cnt); end
        first_x = 'x; first_y = 'x; last_x = 'x; last_y = 'x;
        frame_a();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_f3: locked=%b want 1", locked); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean: err=%b want 0", err); end
        total++; if (first_x !== 8'd0 || first_y !== 8'd0) begin bad++; $display("FAIL first_pixel: got %0d,%0d want 0,0", first_x, first_y); end
        total++; if (last_x !== 8'd11 || last_y !== 8'd5) begin bad++; $display("FAIL last_pixel: got %0d,%0d want 11,5", last_x, last_y); end
        total++; if (stream_err !== 0) begin bad++; $display("FAIL pixel_stream: %0d bad cycles want 0", stream_err); end
    endtask

    task automatic test_mode_switch();
        stream_err = 0;
        frame_b();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL switch_unlock: locked=%b want 0", locked); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL switch_err: err=%b want 1", err); end
        total++; if (h_total !== 8'd16 || v_total !== 8'd8) begin bad++; $display("FAIL switch_meas: got %0d/%0d want 16/8", h_total, v_total); end
        frame_b();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: locked=%b want 0", locked); end
        frame_b();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock: locked=%b want 1", locked); end
        total++; if ({h_total, h_active, v_total, v_active} !== {8'd16, 8'd10, 8'd8, 8'd5}) begin bad++; $display("FAIL relock_timing: got %0d %0d %0d %0d want 16 10 8 5", h_total, h_active, v_total, v_active); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b want 1", err); end
        total++; if (stream_err !== 0) begin bad++; $display("FAIL pixel_stream_b: %0d bad cycles want 0", stream_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        frame_a();
        frame_a();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL sat_pre_err: err=%b want 0", err); end
        gen_frame(20, 2, 4, 12, 260, 0, 1'b0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL sat_err: err=%b want 1", err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sat_locked: locked=%b want 0", locked); end
        frame_a();
        total++; if (v_total !== 8'd255) begin bad++; $display("FAIL sat_v_total: got %0d want 255", v_total); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sat_frame_lock: locked=%b want 0", locked); end
        total++; if (d1_locked !== 1'b0) begin bad++; $display("FAIL sat_frame_lock1: locked=%b want 0", d1_locked); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) frame_a();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL ar_pre_lock: locked=%b want 1", locked); end
        for (int p = 0; p < 8; p++) step(p >= 4, p < 2, 1'b0, CW'(p - 4), 8'd0, 1'b0, 1'b0);
        chk_en = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        total++; if ({pix_vld, locked, frame_start, err, pix_rgb, pix_x} !== '0) begin bad++; $display("FAIL ar_outputs: vld=%b lock=%b rgb=%h x=%0d want 0", pix_vld, locked, pix_rgb, pix_x); end
        total++; if ({h_total, h_active, v_total, v_active} !== '0) begin bad++; $display("FAIL ar_timing: got %0d %0d %0d %0d want 0", h_total, h_active, v_total, v_active); end
        @(negedge sys_clk);
        vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0; vid_rgb = '0;
        p_de = 1'b0; p_rgb = '0; p_first = 1'b0; p_last = 1'b0;
        sys_rst_n = 1'b1;
        chk_en = 1'b1; stream_err = 0;
        frame_a();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_lock_r1: locked=%b want 0", locked); end
        frame_a();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_lock_r2: locked=%b want 0", locked); end
        frame_a();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL ar_lock_r3: locked=%b want 1", locked); end
        total++; if (stream_err !== 0) begin bad++; $display("FAIL ar_stream: %0d bad cycles want 0", stream_err); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mode_switch();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
